updown_modn_counter: RTL and testbench
======================================

Name: updown_modn_counter

Overview:
- Parametrised synchronous up/down modulo-N counter. It is the generalised successor of the team's fixed mod-5 up/down counter.
- Adds configurable modulus, synchronous parallel load, count enable, cascade carry-in/carry-out, an optional saturate mode and load-range error reporting.
- Used as a building block for timers and multi-digit cascaded counters: chain `cout` into the next stage's `cin`.

Parameters:
- MODULUS, 5, number of states; count sequence is 0..MODULUS-1. Must be at least 2.
- WIDTH, 4, width of Q, Qbar and d. Must satisfy 2^WIDTH >= MODULUS; elaboration fails otherwise.
- SATURATE, 0, 0 = wrap at terminal value; 1 = hold at terminal value.

Ports:
- clk  input  1  rising-edge clock.
- R  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- cin  input  1  cascade carry-in. The stage counts only when en & cin. Tie to 1 when unused.
- M  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load strobe.
- d  input  WIDTH  load value.
- Q  output  WIDTH  registered count.
- Qbar  output  WIDTH  bitwise inverse of Q, always ~Q.
- cout  output  1  terminal-count / cascade carry-out, combinational.
- ld_err  output  1  registered one-cycle flag: last load value was out of range.

Behaviour:
- Reset:
  - R low asynchronously forces Q=0, Qbar=all ones, ld_err=0.
  - cout is forced to 0 while R is low.
  - Release is synchronous to the next rising clk edge after R goes high; no count occurs on the release edge unless R is already high at that edge.
- Terminal value: TERM = MODULUS-1 when M=1; TERM = 0 when M=0.
- cout = R & en & cin & (Q == TERM). It is combinational and tracks M, en and cin within the same cycle.
- Priority at each rising edge, highest first:
  1. load=1:
     - If d < MODULUS: Q <= d and ld_err <= 0.
     - Otherwise: Q <= 0 and ld_err <= 1.
     - Load ignores en, cin and M.
  2. en & cin = 1, up count (M=1): Q <= Q+1. At Q = MODULUS-1, Q <= 0 when SATURATE=0, or holds when SATURATE=1.
  3. en & cin = 1, down count (M=0): Q <= Q-1. At Q = 0, Q <= MODULUS-1 when SATURATE=0, or holds when SATURATE=1.
  4. Otherwise: Q holds.
- ld_err is 0 in every cycle that did not follow an out-of-range load.
- Latency:
  - Q updates one edge after the qualifying inputs.
  - cout reflects the current Q with no added latency.
- Direction change: M takes effect on the next edge. No glitch state, and Q never leaves 0..MODULUS-1.
- Illegal state safety: if Q ever holds a value >= MODULUS (e.g. after an SEU), the next enabled count edge forces Q <= 0.
- Saturate mode: cout stays high while holding at TERM with en & cin high.
- Cascade: the next stage advances exactly on the edge where this stage wraps, with no extra cycle.
- Reset mid-count or mid-load: an asynchronous R assertion overrides everything immediately. A load pending on that edge is lost.

Test Plan:
- Reset then count up: R=0, then R=1, en=cin=1, M=1, defaults, 12 edges -> Q = 0,1,2,3,4,0,1,2,3,4,0,1,2. cout=1 exactly while Q=4. Qbar=~Q throughout.
- Count down with wrap, MODULUS=5: load d=1, then M=0 for 3 edges -> Q = 1,0,4,3. cout=1 only while Q=0.
- Out-of-range load and priority: load=1, d=7, en=1 on the same edge -> Q=0, ld_err=1 for one cycle. Then load d=3 -> Q=3, ld_err=0.
- Saturate mode, SATURATE=1, MODULUS=10, WIDTH=4: count up from 7 for 5 edges -> Q = 8,9,9,9,9 with cout held 1. Flip M=0 -> Q=8 on the next edge.
- Cascade of two MODULUS=10 stages, low cout driving high cin: 25 enabled edges from 0 -> high=2, low=5. The high stage increments on the same edges where low goes 9->0.
- Asynchronous reset mid-operation: R pulsed low between edges while Q=3 -> Q=0 and cout=0 immediately, without waiting for a clock edge. After release, counting resumes from 0.

Source files
------------

// File: rtl/updown_modn_counter.sv
// updown_modn_counter: mod-MODULUS up/down counter with load, enable, carry in/out, saturate; ports clk R en cin M load d -> Q Qbar cout ld_err
module updown_modn_counter #(
  parameter int MODULUS  = 5,
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             R,
  input  logic             en,
  input  logic             cin,
  input  logic             M,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             cout,
  output logic             ld_err
);
  if (MODULUS < 2 || ((MODULUS - 1) >> WIDTH) != 0) begin : g_bad_params
    $error("updown_modn_counter: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q_q, q_d, term;
  logic             ld_err_q, ld_err_d, step, at_term, illegal, load_ok;
  always_comb begin
    step     = en & cin;
    term     = M ? MAX : '0;
    at_term  = q_q == term;
    illegal  = q_q > MAX;
    load_ok  = d <= MAX;
    q_d      = load     ? (load_ok ? d : '0) :
               !step    ? q_q :
               illegal  ? '0 :
               at_term  ? ((SATURATE != 0) ? q_q : (M ? '0 : MAX)) :
               M        ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
    ld_err_d = load & ~load_ok;
  end
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      q_q      <= '0;
      ld_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      ld_err_q <= ld_err_d;
    end
  end
  assign Q      = q_q;
  assign Qbar   = ~q_q;
  assign ld_err = ld_err_q;
  assign cout   = R & step & at_term;
endmodule

// File: tb/tb_updown_modn_counter.sv
// tb_updown_modn_counter: directed self-checking bench for updown_modn_counter
module tb_updown_modn_counter;
  logic       clk = 1'b0;
  logic       r_n = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic       en = 1'b0, cin = 1'b1, m = 1'b1, load = 1'b0;
  logic [3:0] d = '0;
  logic [3:0] q, qbar;
  logic       cout, ld_err;
  logic       s_en = 1'b0, s_m = 1'b1, s_load = 1'b0;
  logic [3:0] s_d = '0;
  logic [3:0] s_q, s_qbar;
  logic       s_cout, s_ld_err;
  logic       c_en = 1'b0;
  logic [3:0] lo_q, lo_qbar, hi_q, hi_qbar;
  logic       lo_cout, lo_ld_err, hi_cout, hi_ld_err;

  always #5 clk = ~clk;

  updown_modn_counter dut (
    .clk(clk), .R(r_n), .en(en), .cin(cin), .M(m), .load(load), .d(d),
    .Q(q), .Qbar(qbar), .cout(cout), .ld_err(ld_err)
  );
  updown_modn_counter #(.MODULUS(10), .WIDTH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .R(r_n), .en(s_en), .cin(1'b1), .M(s_m), .load(s_load), .d(s_d),
    .Q(s_q), .Qbar(s_qbar), .cout(s_cout), .ld_err(s_ld_err)
  );
  updown_modn_counter #(.MODULUS(10), .WIDTH(4)) dut_lo (
    .clk(clk), .R(r_n), .en(c_en), .cin(1'b1), .M(1'b1), .load(1'b0), .d(4'd0),
    .Q(lo_q), .Qbar(lo_qbar), .cout(lo_cout), .ld_err(lo_ld_err)
  );
  updown_modn_counter #(.MODULUS(10), .WIDTH(4)) dut_hi (
    .clk(clk), .R(r_n), .en(c_en), .cin(lo_cout), .M(1'b1), .load(1'b0), .d(4'd0),
    .Q(hi_q), .Qbar(hi_qbar), .cout(hi_cout), .ld_err(hi_ld_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1; cin = 1'b1; m = 1'b0;
    #12;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q got %0d want 0", q); end
    checks++; if (qbar !== 4'hf) begin errors++; $display("FAIL reset_qbar got %h want f", qbar); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL reset_ld_err got %b want 0", ld_err); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
    tick();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_hold_q got %0d want 0", q); end
  endtask

  task automatic test_count_up();
    logic [3:0] exp;
    m = 1'b1; en = 1'b1; cin = 1'b1;
    r_n = 1'b1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL up_start got %0d want 0", q); end
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = 4'(i % 5);
      checks++; if (q !== exp) begin errors++; $display("FAIL up_q edge %0d got %0d want %0d", i, q, exp); end
      checks++; if (qbar !== ~exp) begin errors++; $display("FAIL up_qbar edge %0d got %h want %h", i, qbar, ~exp); end
      checks++; if (cout !== (exp == 4'd4)) begin errors++; $display("FAIL up_cout edge %0d got %b want %b", i, cout, exp == 4'd4); end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp [3] = '{4'd0, 4'd4, 4'd3};
    load = 1'b1; d = 4'd1;
    tick();
    load = 1'b0; m = 1'b0;
    #1;
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL down_load got %0d want 1", q); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL down_cout_at1 got %b want 0", cout); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== exp[i]) begin errors++; $display("FAIL down_q step %0d got %0d want %0d", i, q, exp[i]); end
      checks++; if (cout !== (exp[i] == 4'd0)) begin errors++; $display("FAIL down_cout step %0d got %b want %b", i, cout, exp[i] == 4'd0); end
    end
  endtask

  task automatic test_load_err();
    m = 1'b1; en = 1'b1; load = 1'b1; d = 4'd7;
    tick();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL ld7_q got %0d want 0", q); end
    checks++; if (ld_err !== 1'b1) begin errors++; $display("FAIL ld7_err got %b want 1", ld_err); end
    d = 4'd3;
    tick();
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL ld3_q got %0d want 3", q); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL ld3_err got %b want 0", ld_err); end
    d = 4'd5;
    tick();
    checks++; if (q !== 4'd0 || ld_err !== 1'b1) begin errors++; $display("FAIL ld5 got q=%0d err=%b want q=0 err=1", q, ld_err); end
    d = 4'd4; m = 1'b0; en = 1'b0;
    tick();
    checks++; if (q !== 4'd4 || ld_err !== 1'b0) begin errors++; $display("FAIL ld4 got q=%0d err=%b want q=4 err=0", q, ld_err); end
    load = 1'b0; d = 4'd9;
    tick();
    checks++; if (q !== 4'd4 || ld_err !== 1'b0) begin errors++; $display("FAIL ld_idle got q=%0d err=%b want q=4 err=0", q, ld_err); end
  endtask

  task automatic test_hold();
    m = 1'b1; en = 1'b1; cin = 1'b0;
    #1;
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL hold_cin_cout got %b want 0", cout); end
    tick();
    checks++; if (q !== 4'd4) begin errors++; $display("FAIL hold_cin got %0d want 4", q); end
    cin = 1'b1;
    #1;
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL hold_cout_up got %b want 1", cout); end
    m = 1'b0;
    #1;
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL cout_tracks_m got %b want 0", cout); end
    en = 1'b0;
    tick();
    checks++; if (q !== 4'd4) begin errors++; $display("FAIL hold_en got %0d want 4", q); end
  endtask

  task automatic test_saturate();
    logic [3:0] exp [5] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    s_load = 1'b1; s_d = 4'd7;
    tick();
    s_load = 1'b0; s_en = 1'b1; s_m = 1'b1;
    checks++; if (s_q !== 4'd7) begin errors++; $display("FAIL sat_load got %0d want 7", s_q); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (s_q !== exp[i]) begin errors++; $display("FAIL sat_q step %0d got %0d want %0d", i, s_q, exp[i]); end
      checks++; if (s_cout !== (exp[i] == 4'd9)) begin errors++; $display("FAIL sat_cout step %0d got %b want %b", i, s_cout, exp[i] == 4'd9); end
    end
    s_m = 1'b0;
    tick();
    checks++; if (s_q !== 4'd8) begin errors++; $display("FAIL sat_down got %0d want 8", s_q); end
    s_load = 1'b1; s_d = 4'd0;
    tick();
    s_load = 1'b0;
    tick();
    checks++; if (s_q !== 4'd0 || s_cout !== 1'b1) begin errors++; $display("FAIL sat_zero got q=%0d cout=%b want q=0 cout=1", s_q, s_cout); end
    s_en = 1'b0;
  endtask

  task automatic test_cascade();
    logic [3:0] lo = 4'd0, hi = 4'd0;
    checks++; if (lo_q !== 4'd0 || hi_q !== 4'd0) begin errors++; $display("FAIL casc_start got hi=%0d lo=%0d want 0 0", hi_q, lo_q); end
    c_en = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (lo == 4'd9) begin lo = 4'd0; hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1; end
      else lo = lo + 4'd1;
      checks++; if (lo_q !== lo || hi_q !== hi) begin errors++; $display("FAIL casc edge %0d got hi=%0d lo=%0d want hi=%0d lo=%0d", i, hi_q, lo_q, hi, lo); end
    end
    checks++; if (hi_q !== 4'd2 || lo_q !== 4'd5) begin errors++; $display("FAIL casc_final got hi=%0d lo=%0d want 2 5", hi_q, lo_q); end
    c_en = 1'b0;
  endtask

  task automatic test_async_reset();
    en = 1'b0; load = 1'b1; d = 4'd3;
    tick();
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL ar_pre got %0d want 3", q); end
    d = 4'd9; m = 1'b0; en = 1'b1; cin = 1'b1;
    #3;
    r_n = 1'b0;
    #1;
    checks++; if (q !== 4'd0 || qbar !== 4'hf) begin errors++; $display("FAIL ar_q got q=%0d qbar=%h want 0 f", q, qbar); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ar_cout got %b want 0", cout); end
    tick();
    checks++; if (q !== 4'd0 || ld_err !== 1'b0) begin errors++; $display("FAIL ar_load_lost got q=%0d err=%b want 0 0", q, ld_err); end
    load = 1'b0; m = 1'b1;
    r_n = 1'b1;
    tick();
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL ar_resume1 got %0d want 1", q); end
    tick();
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL ar_resume2 got %0d want 2", q); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_err();
    test_hold();
    test_saturate();
    test_cascade();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
